// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle MIPS main control FSM and its datapath.
// The controller drives every control line. The datapath supplies the
// instruction opcode and the memory completion strobe.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       BranchNE;
    logic [1:0] PCSource;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic       ZeroExt;
    logic       LuiSel;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
               PCWrite, PCWriteCond, BranchNE, PCSource, ALUSrcA, ALUSrcB,
               ALUOp, ZeroExt, LuiSel, illegal_op, state
    );

    modport slave (
        output opcode, mem_ready,
        input  IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
               PCWrite, PCWriteCond, BranchNE, PCSource, ALUSrcA, ALUSrcB,
               ALUOp, ZeroExt, LuiSel, illegal_op, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Steps each instruction through fetch/decode/execute/memory/write-back and
// drives the datapath controls combinationally from the state, the latched
// opcode and mem_ready. All controls read 0 while rst_n is low.
// Build option: define MULTICYCLE_LUI_EN to decode LUI (6'h0F); otherwise
// LUI is treated as an illegal opcode and LuiSel stays 0.
module multicycle_control (
    input  logic                       clk,
    input  logic                       rst_n,
    multicycle_control_if.master       bus
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
`ifdef MULTICYCLE_LUI_EN
    localparam logic [5:0] OP_LUI  = 6'h0F;
`endif

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXEC = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       lui_sel_c;

    // LUI selection only exists when the feature is built in
`ifdef MULTICYCLE_LUI_EN
    assign lui_sel_c = (op_q == OP_LUI);
`else
    assign lui_sel_c = 1'b0;
`endif

    // Next-state logic; opcode is captured as DECODE is left
    always_comb begin
        state_d = S_FETCH;
        op_d    = op_q;
        case (state_q)
            S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                op_d = bus.opcode;
                case (bus.opcode)
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_R:             state_d = S_RTEXEC;
                    OP_BEQ, OP_BNE:   state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI: state_d = S_IEXEC;
`ifdef MULTICYCLE_LUI_EN
                    OP_LUI:           state_d = S_IEXEC;
`endif
                    OP_J:             state_d = S_JUMP;
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_RTEXEC: state_d = S_RTWB;
            S_IEXEC:  state_d = S_IWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // State and latched opcode registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= 6'h00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Per-state control decode; everything is held at 0 during reset
    always_comb begin
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.BranchNE    = 1'b0;
        bus.PCSource    = 2'b00;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = 3'b000;
        bus.ZeroExt     = 1'b0;
        bus.LuiSel      = 1'b0;
        bus.illegal_op  = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    bus.ALUOp   = 3'b010;
                    bus.IRWrite = bus.mem_ready;
                    bus.PCWrite = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.ALUSrcB = 2'b11;
                    bus.ALUOp   = 3'b010;
                    // An opcode that leaves DECODE straight to FETCH is unknown
                    bus.illegal_op = (state_d == S_FETCH);
                end
                S_MEMADR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                    bus.ALUOp   = 3'b010;
                end
                S_MEMRD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                end
                S_MEMWB: begin
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = 1'b1;
                end
                S_MEMWR: begin
                    bus.MemWrite = 1'b1;
                    bus.IorD     = 1'b1;
                end
                S_RTEXEC: bus.ALUSrcA = 1'b1;
                S_RTWB: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = 1'b1;
                end
                S_BRANCH: begin
                    bus.ALUSrcA     = 1'b1;
                    bus.ALUOp       = 3'b001;
                    bus.PCWriteCond = 1'b1;
                    bus.PCSource    = 2'b01;
                    bus.BranchNE    = (op_q == OP_BNE);
                end
                S_IEXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                    bus.ZeroExt = (op_q == OP_ANDI);
                    bus.LuiSel  = lui_sel_c;
                    if (op_q == OP_ADDI)      bus.ALUOp = 3'b011;
                    else if (op_q == OP_ANDI) bus.ALUOp = 3'b100;
                    else                      bus.ALUOp = 3'b010;
                end
                S_IWB: begin
                    bus.RegWrite = 1'b1;
                    bus.ZeroExt  = (op_q == OP_ANDI);
                    bus.LuiSel   = lui_sel_c;
                end
                S_JUMP: begin
                    bus.PCWrite  = 1'b1;
                    bus.PCSource = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign bus.state = rst_n ? state_q : 4'd0;

endmodule
